booth_feeder: RTL and testbench

Operand sequencer and result collector wrapped around the 32x32 signed Booth multiplier. Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. Drives the multiplier's `load`/`a`/`b` inputs with the one-cycle load / one-cycle compute protocol, then captures the 64-bit product and presents it on a valid/ready result stream. Sits directly upstream and downstream of the multiplier: its `mul_*` outputs connect to the multiplier's inputs, and `mul_out` comes from the multiplier's output.

---
 rtl/booth_feeder.sv | 111 +++++++++++
 tb/tb_booth_feeder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_feeder.sv
// Operand FIFO and load/compute/capture sequencer wrapped around a 32x32 signed Booth
// multiplier, with a valid/ready result stream.
module booth_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [W-1:0]           i_in_a,
  input  logic [W-1:0]           i_in_b,
  output logic                   o_mul_load,
  output logic [W-1:0]           o_mul_a,
  output logic [W-1:0]           o_mul_b,
  input  logic [2*W-1:0]         i_mul_out,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [2*W-1:0]         o_res_data,
  output logic [$clog2(DEPTH):0] o_fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {StIdle, StLoad, StCalc, StCapt, StHold} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [W-1:0]    r_mem_a [DEPTH];
  logic [W-1:0]    r_mem_b [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_mul_load;
  logic [W-1:0]    r_mul_a;
  logic [W-1:0]    r_mul_b;
  logic            r_res_valid;
  logic [2*W-1:0]  r_res_data;
  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;

  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = i_in_valid && w_in_ready;
  assign w_pop      = (r_state == StIdle) && (r_count != '0);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_pop) w_state_d = StLoad;
      StLoad: w_state_d = StCalc;
      StCalc: w_state_d = StCapt;
      StCapt: w_state_d = StHold;
      StHold: if (i_res_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Storage is not reset; occupancy and pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= i_in_a;
      r_mem_b[r_wr_ptr] <= i_in_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_mul_load  <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_mul_load <= (w_state_d == StLoad);
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_mul_a  <= r_mem_a[r_rd_ptr];
        r_mul_b  <= r_mem_b[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      // Product is registered by the multiplier on the CALC edge, so it is sampled here.
      if (r_state == StCapt) begin
        r_res_data  <= i_mul_out;
        r_res_valid <= 1'b1;
      end else if ((r_state == StHold) && i_res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_mul_load   = r_mul_load;
  assign o_mul_a      = r_mul_a;
  assign o_mul_b      = r_mul_b;
  assign o_res_valid  = r_res_valid;
  assign o_res_data   = r_res_data;
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_booth_feeder.sv
// Bench for booth_feeder: behavioral multiplier model plus a result scoreboard.
module tb_booth_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mul_load;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_out = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_data;
  logic [2:0]  fifo_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  logic [63:0] sb[$];
  logic [63:0] got_q[$];
  bit          prev_stall = 1'b0;
  logic [63:0] prev_data = '0;

  booth_feeder #(.DEPTH(4), .W(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_a      (in_a),
    .i_in_b      (in_b),
    .o_mul_load  (mul_load),
    .o_mul_a     (mul_a),
    .o_mul_b     (mul_b),
    .i_mul_out   (mul_out),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb_;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    return 64'(sa * sb_);
  endfunction

  // Multiplier: latches operands on the load edge, registers the product one edge later.
  // Between products the output carries a poison pattern so mistimed captures show up.
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic        m_ld_q = 1'b0;
  always @(posedge clk) begin
    if (mul_load === 1'b1) begin
      m_a <= mul_a;
      m_b <= mul_b;
    end
    m_ld_q  <= (mul_load === 1'b1);
    mul_out <= m_ld_q ? prod(m_a, m_b) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  // Scoreboard: expect on accepted push, compare on transferred result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(prod(in_a, in_b));
      if (prev_stall && res_valid) begin
        n_checks++;
        if (res_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_stable: res_data=%h required %h", res_data, prev_data);
        end
      end
      if (res_valid && res_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: res_data=%h required none", res_data);
        end else begin
          logic [63:0] exp;
          exp = sb.pop_front();
          if (res_data !== exp) begin
            n_fail++;
            $display("FAIL result: res_data=%h required %h", res_data, exp);
          end
        end
        got_q.push_back(res_data);
        n_out++;
      end
      prev_stall = res_valid && !res_ready;
      prev_data  = res_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    bit acc;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 500 && !done; t++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && res_valid === 1'b0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++;
    if (res_valid !== 1'b0 || mul_load !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0 ||
        res_data !== 64'h0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: rv=%b ld=%b a=%h b=%h rd=%h cnt=%0d rdy=%b required 0 0 0 0 0 0 1",
               res_valid, mul_load, mul_a, mul_b, res_data, fifo_count, in_ready);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (mul_load !== 1'b0 || res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: mul_load=%b res_valid=%b required 0 0", k, mul_load, res_valid);
      end
    end
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    push(32'd3, 32'd5);  // returns just after push edge T
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (mul_load !== (k == 1) || res_valid !== (k == 4)) begin
        n_fail++;
        $display("FAIL single_T+%0d: mul_load=%b res_valid=%b required %b %b",
                 k, mul_load, res_valid, (k == 1), (k == 4));
      end
      if (k == 4) begin
        n_checks++;
        if (res_data !== 64'h0000_0000_0000_000F) begin
          n_fail++;
          $display("FAIL single_data: res_data=%h required 000000000000000f", res_data);
        end
      end
    end
    wait_drain("single");
  endtask

  task automatic test_signed();
    int base;
    base = got_q.size();
    res_ready = 1'b1;
    push(32'hFFFF_FFFF, 32'h0000_0001);
    push(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    in_valid = 1'b0;
    wait_drain("signed");
    n_checks++;
    if (got_q.size() != base + 2 || got_q[base] !== 64'hFFFF_FFFF_FFFF_FFFF ||
        got_q[base+1] !== 64'h3FFF_FFFF_0000_0001) begin
      n_fail++;
      $display("FAIL signed_order: got %0d results required 2 (ffffffffffffffff, 3fffffff00000001)",
               got_q.size() - base);
    end
  endtask

  task automatic test_backpressure();
    int base;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(i * 1000 - 7);
      in_b     = 32'(-(i + 3) * 77);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: cnt=%0d rdy=%b rv=%b required 4 0 1", fifo_count, in_ready, res_valid);
    end
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (fifo_count !== 3'd4 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stalled: cnt=%0d rv=%b required 4 1", fifo_count, res_valid);
    end
    base = n_out;
    res_ready = 1'b1;
    wait_drain("bp");
    n_checks++;
    if (n_out - base != 5) begin
      n_fail++;
      $display("FAIL bp_count: results=%0d required 5", n_out - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_out;
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(32'(i * 32'h1234_5679 + 1), 32'(32'h8000_0001 + i * 3));
      n_checks++;
      if (fifo_count > 3'd4) begin
        n_fail++;
        $display("FAIL b2b_count: cnt=%0d required <= 4", fifo_count);
      end
    end
    in_valid = 1'b0;
    wait_drain("b2b");
    n_checks++;
    if (n_out - base != 10) begin
      n_fail++;
      $display("FAIL b2b_results: results=%0d required 10", n_out - base);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 32'(100 + i);
      in_b     = 32'(200 + i);
      @(posedge clk);
      #1;
      if (i == 1) begin
        n_checks++;
        if (mul_load !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_load: mul_load=%b required 1", mul_load);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd2 || mul_load !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_calc: cnt=%0d mul_load=%b required 2 0", fifo_count, mul_load);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    n_checks++;
    if (res_valid !== 1'b0 || fifo_count !== 3'd0 || mul_load !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rv=%b cnt=%0d ld=%b required 0 0 0", res_valid, fifo_count, mul_load);
    end
    base = n_out;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (res_valid !== 1'b0 || mul_load !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_quiet%0d: rv=%b ld=%b required 0 0", k, res_valid, mul_load);
      end
    end
    push(32'hFFFF_FFF9, 32'd6);
    in_valid = 1'b0;
    wait_drain("mid");
    n_checks++;
    if (n_out - base != 1 || got_q[got_q.size()-1] !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      n_fail++;
      $display("FAIL mid_after: results=%0d last=%h required 1 ffffffffffffffd6",
               n_out - base, got_q[got_q.size()-1]);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
